// File: rtl/alu_seq_pkg.sv
// Shared encodings for the alu sequencer and its datapath.
package alu_seq_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned OFF9_W   = 9;

    // Instruction field bit positions
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RA_MSB  = 8;
    localparam int unsigned RA_LSB  = 6;
    localparam int unsigned RB_MSB  = 5;
    localparam int unsigned RB_LSB  = 3;
    localparam int unsigned IMM_MSB = 5;
    localparam int unsigned OFF_MSB = 8;

    // Opcodes with op[3] = 1; op[3] = 0 is an alu instruction
    localparam logic [OP_W-1:0] OP_NOP  = 4'b1000;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1001;
    localparam logic [OP_W-1:0] OP_BRZ  = 4'b1010;
    localparam logic [OP_W-1:0] OP_BRN  = 4'b1011;
    localparam logic [OP_W-1:0] OP_BRO  = 4'b1100;
    localparam logic [OP_W-1:0] OP_BRA  = 4'b1101;
    localparam logic [OP_W-1:0] OP_RSV  = 4'b1110;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    // Write-back source select
    localparam logic WR_SEL_SUM = 1'b0;
    localparam logic WR_SEL_IMM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

endpackage

// File: rtl/alu_seq_pc.sv
// Program counter: clear, increment, or increment plus signed branch offset.
module alu_seq_pc
    import alu_seq_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_clr,
    input  logic              pc_inc,
    input  logic              pc_br,
    input  logic [OFF9_W-1:0] off9,
    output logic [PC_W-1:0]   pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] off_ext_c;

    // Next pc; all arithmetic wraps at PC_W bits
    always_comb begin
        off_ext_c = PC_W'($signed(off9));
        pc_d      = pc_q;
        if (pc_clr) begin
            pc_d = '0;
        end else if (pc_br) begin
            pc_d = pc_q + PC_W'(1) + off_ext_c;
        end else if (pc_inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // pc register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM running a program on the alu + register-file datapath.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                z_flag,
    input  logic                n_flag,
    input  logic                o_flag,
    output logic [PC_W-1:0]     pc,
    output logic [REG_AW-1:0]   rf_ra,
    output logic [REG_AW-1:0]   rf_rb,
    output logic [REG_AW-1:0]   rf_wa,
    output logic                rf_we,
    output logic                wr_sel,
    output logic [DATA_W-1:0]   imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_en,
    output logic                busy,
    output logic                halted
);

    state_e                state_q,  state_d;
    logic [INSTR_W-1:0]    ir_q,     ir_d;
    logic [REG_AW-1:0]     rf_ra_q,  rf_ra_d;
    logic [REG_AW-1:0]     rf_rb_q,  rf_rb_d;
    logic [REG_AW-1:0]     rf_wa_q,  rf_wa_d;
    logic                  rf_we_q,  rf_we_d;
    logic                  wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0]     imm_q,    imm_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic                  alu_en_q, alu_en_d;
    logic                  busy_q,   busy_d;
    logic                  halted_q, halted_d;

    logic                  pc_clr;
    logic                  pc_inc;
    logic                  pc_br;
    logic [OP_W-1:0]       op_c;

    assign op_c = ir_q[OP_MSB:OP_LSB];

    alu_seq_pc #(
        .PC_W (PC_W)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .pc_clr (pc_clr),
        .pc_inc (pc_inc),
        .pc_br  (pc_br),
        .off9   (ir_q[OFF_MSB:0]),
        .pc     (pc)
    );

    // Next state, pc control and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rf_ra_d  = rf_ra_q;
        rf_rb_d  = rf_rb_q;
        rf_wa_d  = rf_wa_q;
        imm_d    = imm_q;
        alu_op_d = alu_op_q;
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        pc_br    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Operand fields are presented from DECODE on and held until the next fetch
                ir_d     = instr;
                rf_ra_d  = instr[RA_MSB:RA_LSB];
                rf_rb_d  = instr[RB_MSB:RB_LSB];
                alu_op_d = instr[OP_LSB+ALU_OP_W-1:OP_LSB];
                imm_d    = DATA_W'($signed(instr[IMM_MSB:0]));
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                case (op_c)
                    OP_NOP, OP_RSV: begin
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_LDI:  state_d = ST_WB;
                    OP_BRZ: begin
                        pc_inc  = 1'b1;
                        pc_br   = z_flag;
                        state_d = ST_FETCH;
                    end
                    OP_BRN: begin
                        pc_inc  = 1'b1;
                        pc_br   = n_flag;
                        state_d = ST_FETCH;
                    end
                    OP_BRO: begin
                        pc_inc  = 1'b1;
                        pc_br   = o_flag;
                        state_d = ST_FETCH;
                    end
                    OP_BRA: begin
                        pc_inc  = 1'b1;
                        pc_br   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_HALT: state_d = ST_HALTED;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                pc_inc  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_WB) begin
            rf_wa_d = ir_q[RD_MSB:RD_LSB];
        end

        rf_we_d  = (state_d == ST_WB);
        wr_sel_d = ((state_d == ST_WB) && (op_c == OP_LDI)) ? WR_SEL_IMM : WR_SEL_SUM;
        alu_en_d = (state_d == ST_EXEC);
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                   (state_d == ST_EXEC)  || (state_d == ST_WB);
        halted_d = (state_d == ST_HALTED);
    end

    // State, IR and output registers; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            rf_ra_q  <= '0;
            rf_rb_q  <= '0;
            rf_wa_q  <= '0;
            rf_we_q  <= 1'b0;
            wr_sel_q <= WR_SEL_SUM;
            imm_q    <= '0;
            alu_op_q <= '0;
            alu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            rf_ra_q  <= rf_ra_d;
            rf_rb_q  <= rf_rb_d;
            rf_wa_q  <= rf_wa_d;
            rf_we_q  <= rf_we_d;
            wr_sel_q <= wr_sel_d;
            imm_q    <= imm_d;
            alu_op_q <= alu_op_d;
            alu_en_q <= alu_en_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign rf_ra  = rf_ra_q;
    assign rf_rb  = rf_rb_q;
    assign rf_wa  = rf_wa_q;
    assign rf_we  = rf_we_q;
    assign wr_sel = wr_sel_q;
    assign imm    = imm_q;
    assign alu_op = alu_op_q;
    assign alu_en = alu_en_q;
    assign busy   = busy_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: emulated alu/register file, instruction-level reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr;
    logic        z_flag, n_flag, o_flag;
    logic [7:0]  pc;
    logic [2:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we, wr_sel;
    logic [7:0]  imm;
    logic [2:0]  alu_op;
    logic        alu_en, busy, halted;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rom [256];
    logic [7:0]  rf  [8];
    logic [7:0]  sum_q;
    logic        z_q = 1'b0, n_q = 1'b0, o_q = 1'b0;

    typedef struct packed {
        logic [7:0] pc;
        logic       busy;
        logic       halted;
        logic       we;
        logic       en;
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] wa;
        logic       ws;
        logic [7:0] wd;
    } exp_t;

    exp_t exp_q [$];

    alu_sequencer #(
        .DATA_W (8),
        .PC_W   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .instr  (instr),
        .z_flag (z_flag),
        .n_flag (n_flag),
        .o_flag (o_flag),
        .pc     (pc),
        .rf_ra  (rf_ra),
        .rf_rb  (rf_rb),
        .rf_wa  (rf_wa),
        .rf_we  (rf_we),
        .wr_sel (wr_sel),
        .imm    (imm),
        .alu_op (alu_op),
        .alu_en (alu_en),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    assign instr  = rom[pc];
    assign z_flag = z_q;
    assign n_flag = n_q;
    assign o_flag = o_q;

    // Bench alu: returns {o, n, z, result}
    function automatic logic [10:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       o;
        o = 1'b0;
        case (op)
            3'd0: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; o = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = {a[6:0], 1'b0};
            3'd6: r = {1'b0, a[7:1]};
            default: r = b;
        endcase
        return {o, r[7], (r == 8'd0), r};
    endfunction

    // Emulated datapath: registered alu result/flags and register file
    always @(posedge clk) begin
        if (!rst) begin
            sum_q <= 8'd0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            o_q   <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
        end else begin
            if (alu_en) {o_q, n_q, z_q, sum_q} <= alu_f(alu_op, rf[rf_ra], rf[rf_rb]);
            if (rf_we) rf[rf_wa] <= wr_sel ? imm : sum_q;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_alu(input int op, input int rd, input int ra, input int rb);
        return {1'b0, 3'(op), 3'(rd), 3'(ra), 3'(rb), 3'b000};
    endfunction

    function automatic logic [15:0] enc_ldi(input int rd, input int val);
        return {4'b1001, 3'(rd), 3'b000, 6'(val)};
    endfunction

    function automatic logic [15:0] enc_br(input logic [3:0] op, input int off);
        return {op, 3'b000, 9'(off)};
    endfunction

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    // Random program, weighted so that halts and short branches are common
    task automatic gen_rom();
        int unsigned s;
        int          off;
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            s   = $urandom_range(99);
            w   = 16'($urandom);
            off = int'($urandom_range(16)) - 8;
            if (s < 40)      w[15] = 1'b0;
            else if (s < 60) w[15:12] = 4'b1001;
            else if (s < 82) begin
                w[15:12] = 4'b1010 + 4'($urandom_range(3));
                w[8:0]   = 9'(off);
            end
            else if (s < 94) w[15:12] = (s[0]) ? 4'b1000 : 4'b1110;
            else             w[15:12] = 4'b1111;
            rom[i] = w;
        end
    endtask

    // Instruction-level model: expected per-cycle outputs from the program's semantics
    task automatic build_trace(input int max_cyc);
        logic [7:0]  r [8];
        logic        z, n, o, taken;
        int          p;
        logic [15:0] w;
        logic [3:0]  op;
        logic [10:0] a;
        exp_t        e, base;
        bit          done;
        for (int i = 0; i < 8; i++) r[i] = 8'd0;
        z = 1'b0; n = 1'b0; o = 1'b0; p = 0; done = 1'b0;
        exp_q.delete();
        while (!done && exp_q.size() < max_cyc) begin
            w    = rom[p];
            op   = w[15:12];
            base = '0;
            base.pc   = 8'(p);
            base.busy = 1'b1;
            exp_q.push_back(base);
            exp_q.push_back(base);
            if (!op[3]) begin
                a = alu_f(op[2:0], r[w[8:6]], r[w[5:3]]);
                e = base; e.en = 1'b1; e.op = op[2:0]; e.ra = w[8:6]; e.rb = w[5:3];
                exp_q.push_back(e);
                e = base; e.we = 1'b1; e.wa = w[11:9]; e.ws = 1'b0; e.wd = a[7:0];
                exp_q.push_back(e);
                r[w[11:9]] = a[7:0];
                {o, n, z} = a[10:8];
                p = (p + 1) & 255;
            end else begin
                case (op)
                    4'b1001: begin
                        e = base; e.we = 1'b1; e.wa = w[11:9]; e.ws = 1'b1;
                        e.wd = 8'($signed(w[5:0]));
                        exp_q.push_back(e);
                        r[w[11:9]] = e.wd;
                        p = (p + 1) & 255;
                    end
                    4'b1111: begin
                        e = '0; e.pc = 8'(p); e.halted = 1'b1;
                        exp_q.push_back(e);
                        done = 1'b1;
                    end
                    4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
                        taken = (op == 4'b1010) ? z : (op == 4'b1011) ? n :
                                (op == 4'b1100) ? o : 1'b1;
                        p = (p + 1 + (taken ? int'($signed(w[8:0])) : 0)) & 255;
                    end
                    default: p = (p + 1) & 255;
                endcase
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reset, start, compare every cycle to the model, then try a restart from HALTED
    task automatic run_prog(input string name, input bit rand_start);
        exp_t       e;
        logic [7:0] wd;
        do_reset();
        build_trace(200);
        start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            e  = exp_q[k];
            wd = wr_sel ? imm : sum_q;
            check_eq($sformatf("%s ctl[%0d]", name, k), {pc, busy, halted, rf_we, alu_en},
                     {e.pc, e.busy, e.halted, e.we, e.en});
            if (e.en) check_eq($sformatf("%s alu[%0d]", name, k), {alu_op, rf_ra, rf_rb}, {e.op, e.ra, e.rb});
            if (e.we) check_eq($sformatf("%s wb[%0d]", name, k), {rf_wa, wr_sel, wd}, {e.wa, e.ws, e.wd});
            start = (rand_start && e.busy) ? 1'($urandom_range(1)) : 1'b0;
        end
        if (exp_q[exp_q.size()-1].halted) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq($sformatf("%s restart", name), {pc, busy, halted}, {8'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit found;

        // Reset state, idle with start low
        fill_rom(16'hF000);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_eq("reset_idle", {pc, busy, halted, rf_we, alu_en}, 12'd0);
            @(negedge clk);
        end

        // LDI r1,2; LDI r2,4; add r3,r1,r2; HALT
        fill_rom(16'hF000);
        rom[0] = enc_ldi(1, 2);
        rom[1] = enc_ldi(2, 4);
        rom[2] = enc_alu(0, 3, 1, 2);
        run_prog("prog_add", 1'b0);
        check_eq("prog_add r3", {24'd0, rf[3]}, 32'd6);

        // BRZ -3 at pc 5 after a zero result, then after a non-zero result
        fill_rom(16'hF000);
        rom[0] = enc_ldi(1, 1);
        rom[1] = enc_br(4'b1101, 2);
        rom[2] = 16'h8000;
        rom[4] = enc_alu(1, 3, 1, 1);
        rom[5] = enc_br(4'b1010, -3);
        run_prog("brz_taken", 1'b0);
        rom[4] = enc_alu(0, 3, 1, 1);
        run_prog("brz_not", 1'b0);

        // BRA +4 at pc 254 wraps to 3
        fill_rom(16'hF000);
        rom[0]   = enc_br(4'b1101, 253);
        rom[254] = enc_br(4'b1101, 4);
        run_prog("pc_wrap", 1'b0);

        // Reset asserted while alu_en is high
        fill_rom(16'hF000);
        rom[0] = enc_alu(0, 1, 0, 0);
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (alu_en) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("rst_wait_exec", {31'd0, found}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("rst_abort", {pc, busy, halted, rf_we, alu_en}, 12'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_quiet", {busy, rf_we, alu_en}, 3'd0);
        end

        // Random programs with start toggled while busy
        for (int t = 0; t < 25; t++) begin
            gen_rom();
            run_prog($sformatf("rand%0d", t), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
